// File: rtl/uart_tx.sv
// UART transmitter: start, WIDTH data bits LSB-first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic [5:0]       Prescale,
  output logic             TX_OUT,
  output logic             Busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic             par_en_q;
  logic             par_typ_q;
  logic [5:0]       last_edge_q;
  logic [5:0]       edge_cnt;
  logic [CNT_W-1:0] bit_cnt;
`ifdef UART_TX_TWO_STOP_EN
  logic             stop_cnt;
`endif

  logic             bit_done;
  logic             parity_bit;
  logic [CNT_W-1:0] bit_nxt;

  // The divider compares against Prescale-1 captured at acceptance, so a
  // Prescale of 0 collapses to the same one-cycle bit as Prescale of 1.
  assign bit_done   = (edge_cnt == last_edge_q);
  assign parity_bit = (^data_q) ^ par_typ_q;
  assign bit_nxt    = bit_cnt + 1'b1;

  // NOTE: every flop here, including the data latch, is reset so the serial
  // line and the whole frame context come up in a known state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      data_q      <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      last_edge_q <= '0;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      TX_OUT      <= 1'b1;
      Busy        <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads
      // the pre-edge values of the registers it depends on.
      if (state != IDLE)
        edge_cnt <= bit_done ? 6'd0 : edge_cnt + 6'd1;

      case (state)
        IDLE: begin
          if (Data_Valid) begin
            data_q      <= P_DATA;
            par_en_q    <= PAR_EN;
            par_typ_q   <= PAR_TYP;
            last_edge_q <= (Prescale == 6'd0) ? 6'd0 : Prescale - 6'd1;
            state       <= START;
            TX_OUT      <= 1'b0;
            Busy        <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_cnt <= '0;
            TX_OUT  <= data_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_cnt == LAST_BIT) begin
              state  <= par_en_q ? PARITY : STOP;
              TX_OUT <= par_en_q ? parity_bit : 1'b1;
            end else begin
              bit_cnt <= bit_nxt;
              TX_OUT  <= data_q[bit_nxt];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state  <= STOP;
            TX_OUT <= 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
`ifdef UART_TX_TWO_STOP_EN
            if (stop_cnt) begin
              state    <= IDLE;
              Busy     <= 1'b0;
              stop_cnt <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
`else
            state <= IDLE;
            Busy  <= 1'b0;
`endif
          end
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
